// File: rtl/sha_digest_tx_pkg.sv
// rtl/sha_digest_tx_pkg.sv - shared types, constants and nibble encoder for the digest transmitter
package sha_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    EOL_CR = 3'd2,
    EOL_LF = 3'd3,
    DONE   = 3'd4
  } sha_tx_state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         SHA3_512_W = 512;

  // Lowercase hex: 0-9 -> '0'-'9', a-f -> 'a'-'f'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/sha_digest_tx.sv
// rtl/sha_digest_tx.sv - streams a captured digest MSB-first as raw bytes or ASCII hex
module sha_digest_tx
  import sha_pkg::*;
#(
  parameter int HASH_W     = SHA3_512_W,
  parameter bit HEX_MODE   = 1'b1,
  parameter bit APPEND_EOL = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HASH_W-1:0] hash_i,
  input  logic              hash_valid_i,
  output logic              hash_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NBYTES = HASH_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  sha_tx_state_t     state_q, state_d;
  logic              armed_q, armed_d;
  logic [HASH_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              nib_sel_q, nib_sel_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic capture;
  logic accept;
  logic last_unit;

  assign hash_ready_o = (state_q == IDLE) && armed_q;
  assign capture      = hash_valid_i && hash_ready_o;
  assign accept       = tx_valid_q && tx_ready_i;
  assign last_unit    = (byte_cnt_q == LAST_BYTE) && (!HEX_MODE || nib_sel_q);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    nib_sel_d  = nib_sel_q;
    armed_d    = armed_q;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;

    // A low valid level at any time re-arms; only a capture disarms.
    if (capture) begin
      armed_d = 1'b0;
    end else if (!hash_valid_i) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          shreg_d    = hash_i;
          byte_cnt_d = '0;
          nib_sel_d  = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (HEX_MODE) begin
            nib_sel_d = ~nib_sel_q;
          end
          if (!HEX_MODE || nib_sel_q) begin
            shreg_d    = shreg_q << 8;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
          if (last_unit) begin
            state_d = APPEND_EOL ? EOL_CR : DONE;
          end
        end
      end
      EOL_CR: if (accept) state_d = EOL_LF;
      EOL_LF: if (accept) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output register is loaded from the next-state view so data holds while stalled.
    case (state_d)
      SEND: begin
        tx_valid_d = 1'b1;
        if (HEX_MODE) begin
          tx_data_d = nib2ascii(nib_sel_d ? shreg_d[HASH_W-5 -: 4] : shreg_d[HASH_W-1 -: 4]);
        end else begin
          tx_data_d = shreg_d[HASH_W-1 -: 8];
        end
      end
      EOL_CR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_CR;
      end
      EOL_LF: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_LF;
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      nib_sel_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      nib_sel_q  <= nib_sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q == SEND) || (state_q == EOL_CR) || (state_q == EOL_LF);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_sha_digest_tx.sv
// tb/tb_sha_digest_tx.sv - directed bench for hex+EOL and raw digest streaming
module tb_sha_digest_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] hx_hash, r_hash;
  logic         hx_hvalid, hx_hready, hx_tvalid, hx_tready, hx_busy, hx_done;
  logic         r_hvalid, r_hready, r_tvalid, r_tready, r_busy, r_done;
  logic [7:0]   hx_tdata, r_tdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] got   [0:255];
  logic [7:0] r_got [0:127];
  int         n_got;

  localparam logic [511:0] PAT = {8{64'h0123456789abcdef}};

  always #5 clk = ~clk;

  sha_digest_tx #(.HASH_W(512), .HEX_MODE(1'b1), .APPEND_EOL(1'b1)) dut_hex (
    .clk_i(clk), .rst_ni(rst_n), .hash_i(hx_hash), .hash_valid_i(hx_hvalid),
    .hash_ready_o(hx_hready), .tx_data_o(hx_tdata), .tx_valid_o(hx_tvalid),
    .tx_ready_i(hx_tready), .busy_o(hx_busy), .done_o(hx_done)
  );

  sha_digest_tx #(.HASH_W(512), .HEX_MODE(1'b0), .APPEND_EOL(1'b0)) dut_raw (
    .clk_i(clk), .rst_ni(rst_n), .hash_i(r_hash), .hash_valid_i(r_hvalid),
    .hash_ready_o(r_hready), .tx_data_o(r_tdata), .tx_valid_o(r_tvalid),
    .tx_ready_i(r_tready), .busy_o(r_busy), .done_o(r_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-derived stream for PAT: nibbles cycle 0..f, then CR LF.
  function automatic logic [7:0] exp_char(input int i);
    int nib;
    if (i == 128) return 8'h0D;
    if (i == 129) return 8'h0A;
    nib = i % 16;
    return (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h61 + nib - 10);
  endfunction

  task automatic run_hex(input bit backpressure, input bit lf_pulse, input string tag);
    int busy_cnt, done_cnt, done_k, stall_err, seq_err, late_valid;
    logic       prev_stall;
    logic [7:0] prev_d;
    busy_cnt = 0; done_cnt = 0; done_k = -1; stall_err = 0; seq_err = 0; late_valid = 0;
    prev_stall = 1'b0; prev_d = 8'h00; n_got = 0;
    chk({tag, "_first_valid"}, {31'b0, hx_tvalid}, 32'd1);
    for (int k = 1; k <= 300; k++) begin
      if (backpressure) hx_tready = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
      else              hx_tready = 1'b1;
      if (lf_pulse) hx_hvalid = (n_got == 129) && hx_tvalid;
      if (prev_stall && (hx_tvalid !== 1'b1 || hx_tdata !== prev_d)) stall_err++;
      if (hx_busy) busy_cnt++;
      if (hx_done) begin
        done_cnt++;
        done_k = k;
      end
      if (done_cnt > 0 && hx_tvalid) late_valid++;
      if (hx_tvalid && hx_tready) begin
        if (n_got < 256) got[n_got] = hx_tdata;
        n_got++;
      end
      prev_stall = hx_tvalid && !hx_tready;
      prev_d     = hx_tdata;
      tick();
    end
    hx_tready = 1'b1;
    for (int i = 0; i < 130 && i < n_got; i++) begin
      if (got[i] !== exp_char(i)) seq_err++;
    end
    chk({tag, "_count"},      n_got,      32'd130);
    chk({tag, "_seq_errs"},   seq_err,    32'd0);
    chk({tag, "_done_count"}, done_cnt,   32'd1);
    chk({tag, "_stall_errs"}, stall_err,  32'd0);
    chk({tag, "_late_valid"}, late_valid, 32'd0);
    if (!backpressure) begin
      chk({tag, "_busy_cycles"}, busy_cnt, 32'd130);
      chk({tag, "_done_cycle"},  done_k,   32'd131);
    end
  endtask

  initial begin
    int rn, rdone_k, zeros, stray, cnt40;
    rst_n = 1'b0;
    hx_hash = '0; hx_hvalid = 1'b0; hx_tready = 1'b1;
    r_hash  = '0; r_hvalid  = 1'b0; r_tready  = 1'b1;
    tick(); tick();

    chk("rst_hx_tvalid", {31'b0, hx_tvalid}, 32'd0);
    chk("rst_hx_tdata",  {24'b0, hx_tdata},  32'd0);
    chk("rst_hx_hready", {31'b0, hx_hready}, 32'd0);
    chk("rst_hx_busy",   {31'b0, hx_busy},   32'd0);
    chk("rst_hx_done",   {31'b0, hx_done},   32'd0);
    chk("rst_r_tvalid",  {31'b0, r_tvalid},  32'd0);
    chk("rst_r_hready",  {31'b0, r_hready},  32'd0);

    rst_n = 1'b1;
    tick();
    chk("armed_hx_hready", {31'b0, hx_hready}, 32'd1);
    chk("armed_r_hready",  {31'b0, r_hready},  32'd1);
    chk("idle_no_tvalid",  {31'b0, hx_tvalid}, 32'd0);

    // Raw mode, no terminator
    r_hash   = {8'hA5, 496'h0, 8'h3C};
    r_hvalid = 1'b1;
    tick();
    r_hvalid = 1'b0;
    r_hash   = '1;
    rn = 0; rdone_k = -1; zeros = 0;
    for (int k = 1; k <= 80; k++) begin
      if (r_done) rdone_k = k;
      if (r_tvalid && r_tready) begin
        if (rn < 128) r_got[rn] = r_tdata;
        rn++;
      end
      tick();
    end
    for (int i = 1; i < 63; i++) if (r_got[i] === 8'h00) zeros++;
    chk("raw_count",      rn,            32'd64);
    chk("raw_first",      {24'b0, r_got[0]},  32'hA5);
    chk("raw_last",       {24'b0, r_got[63]}, 32'h3C);
    chk("raw_mid_zeros",  zeros,         32'd62);
    chk("raw_done_cycle", rdone_k,       32'd65);

    // Hex + EOL, ready held high, digest input scrambled after capture
    hx_hash   = PAT;
    hx_hvalid = 1'b1;
    chk("hex_ready_before_cap", {31'b0, hx_hready}, 32'd1);
    tick();
    hx_hash = ~PAT;
    run_hex(1'b0, 1'b0, "hex_eol");

    // Valid held high: no retransmission
    hx_hash = PAT;
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      if (hx_tvalid || hx_hready || hx_busy) stray++;
      tick();
    end
    chk("hold_no_retx", stray, 32'd0);

    // Drop valid one cycle, then backpressured second transmission
    hx_hvalid = 1'b0;
    tick();
    hx_hvalid = 1'b1;
    chk("rearm_hready", {31'b0, hx_hready}, 32'd1);
    tick();
    run_hex(1'b1, 1'b0, "bp");

    // Reset after 40 accepted bytes
    hx_hvalid = 1'b0;
    tick();
    hx_hvalid = 1'b1;
    tick();
    cnt40 = 0;
    for (int k = 0; k < 100 && cnt40 < 40; k++) begin
      if (hx_tvalid && hx_tready) cnt40++;
      tick();
    end
    chk("pre_reset_bytes", cnt40, 32'd40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_tvalid", {31'b0, hx_tvalid}, 32'd0);
    chk("midrst_busy",   {31'b0, hx_busy},   32'd0);
    chk("midrst_hready", {31'b0, hx_hready}, 32'd0);
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (hx_tvalid || hx_hready) stray++;
    end
    chk("postrst_quiet", stray, 32'd0);
    hx_hvalid = 1'b0;
    tick();
    hx_hvalid = 1'b1;
    chk("postrst_rearm", {31'b0, hx_hready}, 32'd1);
    tick();
    run_hex(1'b0, 1'b0, "restart");

    // Valid pulse during EOL_LF is ignored
    hx_hvalid = 1'b0;
    tick();
    hx_hvalid = 1'b1;
    tick();
    run_hex(1'b0, 1'b1, "lfpulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_digest_tx.md
Name: sha_digest_tx

Overview:
Output-side companion to the SHA3-512 driver. It takes the 512-bit digest and its out_valid level, then streams the digest MSB-first as bytes over a valid/ready byte interface. The consumer is the UART transmitter. The stream can be sent as raw bytes or as lowercase ASCII hex, with an optional CR/LF terminator.

Parameters:
HASH_W, 512, digest width in bits; must be a multiple of 8.
HEX_MODE, 1, 1 = two lowercase ASCII hex chars per byte (high nibble first); 0 = raw bytes.
APPEND_EOL, 1, 1 = append 0x0D then 0x0A after the digest; 0 = no terminator.

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_ni  in  1  reset, synchronous, active-low
hash_i  in  HASH_W  digest from the SHA driver; sampled only on capture
hash_valid_i  in  1  digest-valid level from the SHA driver; may stay high indefinitely
hash_ready_o  out  1  high in IDLE while armed; a capture occurs when this and hash_valid_i are both high
tx_data_o  out  8  byte or character to the UART transmitter
tx_valid_o  out  1  tx_data_o is valid
tx_ready_i  in  1  UART transmitter accepts the byte this cycle
busy_o  out  1  high from the capture cycle+1 through the last accepted byte
done_o  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst_ni=0 at a clock edge): state=IDLE, armed=0, shift register=0, counters=0.
  - All outputs are 0 during and after reset: tx_data_o, tx_valid_o, hash_ready_o, busy_o, done_o.
  - Reset mid-transmission aborts immediately; no further bytes are sent.
- Arming:
  - armed is set when hash_valid_i=0 is sampled. The SHA driver holds out_valid high after completion, so this prevents retransmitting the same digest.
  - hash_ready_o = (state==IDLE) && armed.
- States: IDLE, SEND, EOL_CR, EOL_LF, DONE.
- IDLE:
  - Capture when hash_valid_i && hash_ready_o: shift register <= hash_i; armed <= 0; byte_cnt <= 0; nib_sel <= 0; go to SEND.
- SEND:
  - tx_valid_o=1.
  - Raw mode: tx_data_o = shreg[HASH_W-1 -: 8].
  - Hex mode: tx_data_o = ascii(nibble), with nibble = high nibble when nib_sel=0, low nibble when nib_sel=1. Mapping: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66.
  - Advance only on tx_valid_o && tx_ready_i:
    - Hex mode: toggle nib_sel; on 1->0, shift the register left by 8 and increment byte_cnt.
    - Raw mode: shift and increment on every accept.
  - After the accept of the last char/byte (byte_cnt == HASH_W/8 - 1, and nib_sel==1 in hex mode): go to EOL_CR if APPEND_EOL, else DONE.
- EOL_CR: tx_data_o=0x0D, tx_valid_o=1; on accept go to EOL_LF.
- EOL_LF: tx_data_o=0x0A, tx_valid_o=1; on accept go to DONE.
- DONE: done_o=1 for exactly one cycle, tx_valid_o=0; next state IDLE.
- Handshake rules:
  - tx_data_o and tx_valid_o are registered.
  - Once tx_valid_o is asserted it stays high and tx_data_o stays stable until accepted.
  - tx_valid_o never depends combinationally on tx_ready_i.
  - One byte per cycle when tx_ready_i is held high.
- Latency and totals:
  - First tx_valid_o is asserted the cycle after capture.
  - Totals: hex+EOL = 130 bytes, hex only = 128, raw+EOL = 66, raw only = 64.
  - With tx_ready_i held at 1, the last byte is accepted at capture+N cycles (N = total bytes) and done_o fires the following cycle.
- Boundary conditions:
  - hash_valid_i high during busy: ignored. It is not captured, and armed is re-evaluated continuously; a low seen during SEND still arms.
  - hash_valid_i that rises and falls while busy and before returning to IDLE: not queued.
  - tx_ready_i high while tx_valid_o=0: no effect.
  - hash_i changing after capture: no effect on the stream.
  - byte_cnt width: $clog2(HASH_W/8); wrap is impossible because the counter is reset at capture.

Decomposition:
- Package sha_pkg:
  - state enum sha_tx_state_t (IDLE, SEND, EOL_CR, EOL_LF, DONE)
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, SHA3_512_W=512
  - function nib2ascii(logic [3:0]) -> logic [7:0]
- No sub-module. Nibble encoding is the package function; the whole block is a single FSM plus datapath.

Test Plan:
- Hex+EOL, hash_i=512'h0123456789abcdef repeated 8 times, tx_ready_i=1 -> 130 bytes: 0x30,0x31,0x32,...,0x66 (x8), then 0x0D,0x0A; done_o pulses once; busy_o is high for 130 cycles.
- HEX_MODE=0, APPEND_EOL=0, hash_i = {8'hA5, 496'h0, 8'h3C} -> 64 bytes: first 0xA5, 62 bytes of 0x00, last 0x3C.
- Backpressure: tx_ready_i toggling 1,0,0,1 -> tx_data_o is stable while stalled, no byte is duplicated or dropped, and the full byte sequence matches the first scenario.
- hash_valid_i held high for 500 cycles after the first capture -> exactly one transmission; after hash_valid_i drops for 1 cycle and rises again, a second full transmission follows.
- rst_ni=0 for 1 cycle at byte 40 -> next cycle tx_valid_o=0, busy_o=0, hash_ready_o=0. Once hash_valid_i goes low then high, the stream restarts from the first char 0x30.
- hash_valid_i pulse during EOL_LF -> ignored; done_o fires normally; no second stream.
